// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: RV32 load/store size
// codes, FSM state encoding and small legality helpers.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [0:0] state_t;

   localparam state_t ST_CLEAR = 1'b0;
   localparam state_t ST_READY = 1'b1;

   function automatic logic load_f3_ok(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   function automatic logic store_f3_ok(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W};
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purely combinational byte-lane steering: store lane enables and data
// shift, alignment check, and load lane extraction with sign/zero extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_data,
   output logic        misalign,
   input  logic [2:0]  rd_funct3,
   input  logic [1:0]  rd_addr_lo,
   input  logic [31:0] rd_word,
   output logic [31:0] rd_data
);

   logic [31:0] rd_shift;

   // Store side: place LSB-aligned data into the addressed lanes.
   always_comb begin
      wr_be   = 4'b0000;
      wr_data = 32'h0;
      case (req_size)
         2'b00: begin
            wr_be   = 4'b0001 << req_addr_lo;
            wr_data = req_wdata << {req_addr_lo, 3'b000};
         end
         2'b01: begin
            wr_be   = 4'b0011 << {req_addr_lo[1], 1'b0};
            wr_data = req_wdata << {req_addr_lo[1], 4'b0000};
         end
         2'b10: begin
            wr_be   = 4'b1111;
            wr_data = req_wdata;
         end
         default: begin
            wr_be   = 4'b0000;
            wr_data = 32'h0;
         end
      endcase
   end

   // Halfwords must be 2-byte aligned, words 4-byte aligned.
   always_comb begin
      misalign = ((req_size == 2'b01) && req_addr_lo[0]) ||
                 ((req_size == 2'b10) && (req_addr_lo != 2'b00));
   end

   // Load side: bring the addressed byte/half down to bit 0, then extend.
   always_comb begin
      rd_shift = rd_word >> {rd_addr_lo, 3'b000};
      case (rd_funct3)
         F3_B:    rd_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         F3_H:    rd_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         F3_W:    rd_data = rd_word;
         F3_BU:   rd_data = {24'h0, rd_shift[7:0]};
         F3_HU:   rd_data = {16'h0, rd_shift[15:0]};
         default: rd_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined byte-addressable data memory with a one-cycle response and an
// optional post-reset zeroing sweep (one word per cycle).
module dmem_pipe
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS    = 1024,
   parameter bit CLEAR_ON_RESET = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_done
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t             state;
   logic [IDX_W-1:0]   clr_idx;

   logic               accept;
   logic               req_err;
   logic               high_err;
   logic               f3_ok;
   logic               misalign;
   logic [3:0]         wr_be;
   logic [31:0]        wr_data;

   logic               mem_we;
   logic               mem_re;
   logic [3:0]         mem_be;
   logic [IDX_W-1:0]   mem_idx;
   logic [31:0]        mem_wdata;
   logic [31:0]        rd_word;

   logic               rsp_load;
   logic [2:0]         rd_funct3;
   logic [1:0]         rd_addr_lo;
   logic [31:0]        ld_data;

   // Requests are only taken in READY and never while reset is held.
   always_comb begin
      req_ready = (state == ST_READY) && !rst;
      accept    = req_valid && req_ready;
      init_done = (state == ST_READY);
   end

   // Reject bad size codes, misalignment and addresses beyond the array.
   always_comb begin
      high_err = |req_addr[31:IDX_W+2];
      f3_ok    = req_we ? store_f3_ok(req_funct3) : load_f3_ok(req_funct3);
      req_err  = high_err || misalign || !f3_ok;
   end

   dmem_lane_align u_align (
      .req_size    (req_funct3[1:0]),
      .req_addr_lo (req_addr[1:0]),
      .req_wdata   (req_wdata),
      .wr_be       (wr_be),
      .wr_data     (wr_data),
      .misalign    (misalign),
      .rd_funct3   (rd_funct3),
      .rd_addr_lo  (rd_addr_lo),
      .rd_word     (rd_word),
      .rd_data     (ld_data)
   );

   // Memory port mux: the clear sweep owns the port until READY.
   always_comb begin
      if (state == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_be    = 4'b1111;
         mem_idx   = clr_idx;
         mem_wdata = 32'h0;
         mem_re    = 1'b0;
      end else begin
         mem_we    = accept && req_we && !req_err;
         mem_be    = wr_be;
         mem_idx   = req_addr[IDX_W+1:2];
         mem_wdata = wr_data;
         mem_re    = accept && !req_we;
      end
   end

   // FSM and clear counter; sweep ends after the last index is zeroed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_idx <= '0;
      end else if (state == ST_CLEAR) begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
            state <= ST_READY;
         end
      end
   end

   // One byte-wide array per lane so each lane has its own write enable.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         logic [7:0] rd_byte;

         // Lane write and registered read on the same port.
         always_ff @(posedge clk) begin
            if (mem_we && mem_be[gi]) begin
               lane_mem[mem_idx] <= mem_wdata[8*gi +: 8];
            end
            if (mem_re) begin
               rd_byte <= lane_mem[mem_idx];
            end
         end

         assign rd_word[8*gi +: 8] = rd_byte;
      end
   endgenerate

   // Response stage: remember what kind of access is finishing next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_load   <= 1'b0;
         rd_funct3  <= 3'b000;
         rd_addr_lo <= 2'b00;
      end else begin
         rsp_valid  <= accept;
         rsp_err    <= accept && req_err;
         rsp_load   <= accept && !req_we && !req_err;
         rd_funct3  <= req_funct3;
         rd_addr_lo <= req_addr[1:0];
      end
   end

   // Load data only for successful loads; zero otherwise.
   always_comb begin
      rsp_rdata = (rsp_valid && rsp_load) ? ld_data : 32'h0;
   end

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe: expectations are queued when a request is
// driven and compared when the matching response pulse appears.
module tb_dmem_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_done;

   int          errors = 0;
   int          checks = 0;
   logic [32:0] exp_q[$];
   logic        pend = 1'b0;
   logic [7:0]  mm [64];

   always #5 clk = ~clk;

   dmem_pipe #(.DEPTH_WORDS(16), .CLEAR_ON_RESET(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .init_done  (init_done)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Drive one request for one cycle; queue either the given or modelled result.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit given, input logic gerr,
                        input logic [31:0] grd);
      logic        merr;
      logic [31:0] mrd;
      int          a;
      a    = int'(addr[5:0]);
      merr = (addr[31:6] != 26'h0);
      if (we) begin
         if (!(f3 inside {3'b000, 3'b001, 3'b010})) merr = 1'b1;
      end else begin
         if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) merr = 1'b1;
      end
      if (f3[1:0] == 2'b01 && addr[0]) merr = 1'b1;
      if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) merr = 1'b1;
      mrd = 32'h0;
      if (!merr) begin
         if (we) begin
            case (f3)
               3'b000: mm[a] = wd[7:0];
               3'b001: begin mm[a] = wd[7:0]; mm[a+1] = wd[15:8]; end
               default: begin
                  mm[a] = wd[7:0];    mm[a+1] = wd[15:8];
                  mm[a+2] = wd[23:16]; mm[a+3] = wd[31:24];
               end
            endcase
         end else begin
            case (f3)
               3'b000: mrd = {{24{mm[a][7]}}, mm[a]};
               3'b001: mrd = {{16{mm[a+1][7]}}, mm[a+1], mm[a]};
               3'b010: mrd = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
               3'b100: mrd = {24'h0, mm[a]};
               default: mrd = {16'h0, mm[a+1], mm[a]};
            endcase
         end
      end
      if (given) exp_q.push_back({gerr, grd});
      else       exp_q.push_back({merr, mrd});
      $display("req we=%0b f3=%03b addr=0x%08h wdata=0x%08h", we, f3, addr, wd);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
   endtask

   // Count sampled cycles with req_ready low after reset release (bounded).
   task automatic wait_ready(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) break;
         n++;
      end
   endtask

   // Per-cycle response monitor: pulse timing, payload and idle zeros.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst) begin
         check("rst_req_ready", {31'h0, req_ready}, 32'h0);
         check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
         check("rst_rsp_rdata", rsp_rdata, 32'h0);
         exp_q.delete();
         pend = 1'b0;
      end else begin
         check("rsp_valid", {31'h0, rsp_valid}, {31'h0, pend});
         if (rsp_valid) begin
            $display("rsp rdata=0x%08h err=%0b", rsp_rdata, rsp_err);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e[31:0]);
               check("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
            end
         end else begin
            check("idle_rdata", rsp_rdata, 32'h0);
            check("idle_err", {31'h0, rsp_err}, 32'h0);
         end
         pend = req_valid && req_ready;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 64; i++) mm[i] = 8'h00;

      // Reset and first clear sweep.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_init_done", {31'h0, init_done}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_ready(n);
      check("clear_len", n, 32'd16);
      check("init_done", {31'h0, init_done}, 32'h1);
      @(posedge clk);
      #1;

      // Cleared memory reads zero.
      issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);

      // Store word then sub-word loads with sign/zero extension.
      issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
      issue(1'b0, 3'b000, 32'h9, 32'h0, 1'b1, 1'b0, 32'hFFFFFFBE);
      issue(1'b0, 3'b100, 32'hB, 32'h0, 1'b1, 1'b0, 32'h000000DE);
      issue(1'b0, 3'b101, 32'hA, 32'h0, 1'b1, 1'b0, 32'h0000DEAD);
      issue(1'b0, 3'b001, 32'h8, 32'h0, 1'b1, 1'b0, 32'hFFFFBEEF);

      // Byte merge into an existing word.
      issue(1'b1, 3'b010, 32'h4, 32'h11223344, 1'b1, 1'b0, 32'h0);
      issue(1'b1, 3'b000, 32'h5, 32'h0000007F, 1'b1, 1'b0, 32'h0);
      issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 1'b0, 32'h11227F44);

      // Rejected requests leave memory untouched.
      issue(1'b0, 3'b010, 32'h6, 32'h0, 1'b1, 1'b1, 32'h0);
      issue(1'b0, 3'b001, 32'h3, 32'h0, 1'b1, 1'b1, 32'h0);
      issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
      issue(1'b1, 3'b010, 32'h40, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
      issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 1'b0, 32'h11227F44);

      // Eight back-to-back loads.
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 3'b010, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0);
      end

      // Mixed random traffic against the byte model.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra;
         ra = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) ra = ra | 32'h100;
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra,
               $urandom, 1'b0, 1'b0, 32'h0);
      end
      @(posedge clk);
      @(negedge clk);
      check("sb_drain", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;

      // In-flight load dropped by reset, then reset again mid-sweep.
      issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 64; i++) mm[i] = 8'h00;
      wait_ready(n);
      check("reclear_len", n, 32'd16);
      check("reinit_done", {31'h0, init_done}, 32'h1);
      @(posedge clk);
      #1;
      issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(1'b0, 3'b010, 32'h3C, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("sb_drain_end", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
